pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 127 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline control for a five-stage core: stall priority, exception/ERET
// flush with PC redirect, stall-timeout watchdog and stall-cycle counter.
module pipeline_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
   parameter logic [7:0]  TMO_MAX    = 8'd255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_stall_req,
   input  logic        id_stall_req,
   input  logic        exe_stall_req,
   input  logic        mem_stall_req,
   input  logic        exception_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [3:0]  stall,
   output logic        flush,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        stall_timeout,
   output logic [31:0] stall_cycles
);

   typedef enum logic {
      RUN      = 1'b0,
      REDIRECT = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic [31:0] r_redirect_pc;
   logic [7:0]  r_tmo_cnt;
   logic        r_stall_timeout;
   logic [31:0] r_stall_cycles;
   logic        w_stall_any;

   assign w_stall_any    = |stall;
   assign redirect_pc    = r_redirect_pc;
   assign stall_timeout  = r_stall_timeout;
   assign stall_cycles   = r_stall_cycles;

   // State register: RUN after reset, REDIRECT while a new PC is being fetched.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state: enter REDIRECT on flush, leave once fetch accepts the target.
   // NOTE: the default assignment at the top keeps this combinational block
   // from inferring a latch when no branch below assigns the signal.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         RUN:      if (flush)         w_next_state = REDIRECT;
         REDIRECT: if (!if_stall_req) w_next_state = RUN;
         default:                     w_next_state = RUN;
      endcase
   end

   // Outputs: stall priority and flush; all forced quiet while reset is held.
   always_comb begin
      stall          = 4'b0000;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      if (!rst) begin
         case (r_state)
            RUN: begin
               if (mem_stall_req)                stall = 4'b1111;
               else if (exception_req | eret_req) flush = 1'b1;
               else if (exe_stall_req)           stall = 4'b0111;
               else if (id_stall_req)            stall = 4'b0011;
               else if (if_stall_req)            stall = 4'b0001;
               else                              stall = 4'b0000;
            end
            REDIRECT: begin
               redirect_valid = 1'b1;
               stall          = {3'b000, if_stall_req};
            end
            default: ;
         endcase
      end
   end

   // Redirect target: captured on flush, exception taking precedence over ERET.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_redirect_pc <= 32'h0;
      end else if (flush) begin
         r_redirect_pc <= exception_req ? EXC_VECTOR : epc;
      end
   end

   // Timeout counter: counts consecutive stalled RUN cycles, saturating.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tmo_cnt <= 8'd0;
      end else if ((r_state == RUN) && w_stall_any) begin
         if (r_tmo_cnt < TMO_MAX) r_tmo_cnt <= r_tmo_cnt + 8'd1;
      end else begin
         r_tmo_cnt <= 8'd0;
      end
   end

   // Sticky timeout flag: sets the cycle after the counter reaches saturation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_timeout <= 1'b0;
      end else if (r_tmo_cnt == TMO_MAX) begin
         r_stall_timeout <= 1'b1;
      end
   end

   // Stall-cycle statistic: any stalled cycle in either state, free-wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cycles <= 32'h0;
      end else if (w_stall_any) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, directed corner
// sequences and randomized traffic against a behavioural reference model.
module tb_pipeline_ctrl;

   localparam logic [31:0] EXC = 32'hBFC00380;
   localparam int          TMO = 255;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_stall_req, id_stall_req, exe_stall_req, mem_stall_req;
   logic        exception_req, eret_req;
   logic [31:0] epc;
   logic [3:0]  stall;
   logic        flush, redirect_valid, stall_timeout;
   logic [31:0] redirect_pc, stall_cycles;

   int n_tests = 0;
   int n_fail  = 0;

   pipeline_ctrl dut (
      .clk(clk), .rst(rst),
      .if_stall_req(if_stall_req), .id_stall_req(id_stall_req),
      .exe_stall_req(exe_stall_req), .mem_stall_req(mem_stall_req),
      .exception_req(exception_req), .eret_req(eret_req), .epc(epc),
      .stall(stall), .flush(flush), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .stall_timeout(stall_timeout),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   bit          m_redirect;
   logic [31:0] m_pc;
   int          m_cnt;
   bit          m_timeout;
   logic [31:0] m_cycles;

   task automatic model_reset();
      m_redirect = 0; m_pc = 0; m_cnt = 0; m_timeout = 0; m_cycles = 0;
   endtask

   function automatic logic [3:0] m_stall();
      if (m_redirect)                     return {3'b000, if_stall_req};
      if (mem_stall_req)                  return 4'b1111;
      if (exception_req || eret_req)      return 4'b0000;
      if (exe_stall_req)                  return 4'b0111;
      if (id_stall_req)                   return 4'b0011;
      if (if_stall_req)                   return 4'b0001;
      return 4'b0000;
   endfunction

   function automatic bit m_flush();
      return !m_redirect && (exception_req || eret_req) && !mem_stall_req;
   endfunction

   task automatic model_edge();
      bit stalled;
      bit fl;
      stalled = (m_stall() != 4'b0000);
      fl      = m_flush();
      if (m_cnt == TMO) m_timeout = 1;
      if (stalled) m_cycles = m_cycles + 32'd1;
      if (!m_redirect && stalled) m_cnt = (m_cnt + 1 > TMO) ? TMO : m_cnt + 1;
      else                        m_cnt = 0;
      if (fl) begin
         m_redirect = 1;
         m_pc = exception_req ? EXC : epc;
      end else if (m_redirect && !if_stall_req) begin
         m_redirect = 0;
      end
   endtask

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // req bits: {if, id, exe, mem, exc, eret}
   task automatic drive(input logic [5:0] req, input logic [31:0] e);
      {if_stall_req, id_stall_req, exe_stall_req, mem_stall_req, exception_req, eret_req} = req;
      epc = e;
   endtask

   task automatic compare_model();
      check("model.stall",          32'(stall),          32'(m_stall()));
      check("model.flush",          32'(flush),          32'(m_flush()));
      check("model.redirect_valid", 32'(redirect_valid), 32'(m_redirect));
      check("model.redirect_pc",    redirect_pc,         m_pc);
      check("model.stall_timeout",  32'(stall_timeout),  32'(m_timeout));
      check("model.stall_cycles",   stall_cycles,        m_cycles);
   endtask

   task automatic drive_sample(input logic [5:0] req, input logic [31:0] e);
      drive(req, e);
      @(negedge clk);
      compare_model();
   endtask

   task automatic advance();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic run_cycle(input logic [5:0] req, input logic [31:0] e);
      drive_sample(req, e);
      advance();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".stall"},          32'(stall),          32'h0);
      check({tag, ".flush"},          32'(flush),          32'h0);
      check({tag, ".redirect_valid"}, 32'(redirect_valid), 32'h0);
      check({tag, ".redirect_pc"},    redirect_pc,         32'h0);
      check({tag, ".stall_timeout"},  32'(stall_timeout),  32'h0);
      check({tag, ".stall_cycles"},   stall_cycles,        32'h0);
   endtask

   task automatic do_reset();
      drive(6'b111111, 32'hFFFF_FFFF);
      rst = 1'b1;
      #1;
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      check_reset_outputs("reset_held");
      rst = 1'b0;
      model_reset();
      drive(6'b000000, 32'h0);
   endtask

   typedef struct {
      logic [5:0]  req;
      logic [31:0] epc;
      logic [3:0]  e_stall;
      logic        e_flush;
      logic        e_rv;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vecs[14];

   initial begin
      // Vector table: applied back to back starting right after reset.
      vecs[0]  = '{6'b111100, 32'h0,         4'b1111, 1'b0, 1'b0, 32'h0};
      vecs[1]  = '{6'b111000, 32'h0,         4'b0111, 1'b0, 1'b0, 32'h0};
      vecs[2]  = '{6'b110000, 32'h0,         4'b0011, 1'b0, 1'b0, 32'h0};
      vecs[3]  = '{6'b100000, 32'h0,         4'b0001, 1'b0, 1'b0, 32'h0};
      vecs[4]  = '{6'b000000, 32'h0,         4'b0000, 1'b0, 1'b0, 32'h0};
      vecs[5]  = '{6'b000011, 32'h80001000,  4'b0000, 1'b1, 1'b0, 32'h0};
      vecs[6]  = '{6'b000000, 32'h0,         4'b0000, 1'b0, 1'b1, EXC};
      vecs[7]  = '{6'b000001, 32'h80001000,  4'b0000, 1'b1, 1'b0, EXC};
      vecs[8]  = '{6'b000000, 32'h0,         4'b0000, 1'b0, 1'b1, 32'h80001000};
      vecs[9]  = '{6'b000000, 32'h0,         4'b0000, 1'b0, 1'b0, 32'h80001000};
      vecs[10] = '{6'b010010, 32'h0,         4'b0000, 1'b1, 1'b0, 32'h80001000};
      vecs[11] = '{6'b100010, 32'h0,         4'b0001, 1'b0, 1'b1, EXC};
      vecs[12] = '{6'b000000, 32'h0,         4'b0000, 1'b0, 1'b1, EXC};
      vecs[13] = '{6'b000000, 32'h0,         4'b0000, 1'b0, 1'b0, EXC};

      drive(6'b000000, 32'h0);
      rst = 1'b0;
      #3;
      do_reset();

      for (int i = 0; i < 14; i++) begin
         drive_sample(vecs[i].req, vecs[i].epc);
         check($sformatf("vec%0d.stall", i), 32'(stall),          32'(vecs[i].e_stall));
         check($sformatf("vec%0d.flush", i), 32'(flush),          32'(vecs[i].e_flush));
         check($sformatf("vec%0d.rv", i),    32'(redirect_valid), 32'(vecs[i].e_rv));
         check($sformatf("vec%0d.pc", i),    redirect_pc,         vecs[i].e_pc);
         advance();
      end

      // Exception held off by a three-cycle data stall.
      for (int i = 0; i < 3; i++) begin
         drive_sample(6'b000110, 32'h0);
         check($sformatf("mwait%0d.stall", i), 32'(stall), 32'hF);
         check($sformatf("mwait%0d.flush", i), 32'(flush), 32'h0);
         advance();
      end
      drive_sample(6'b000010, 32'h0);
      check("mwait.flush_rise", 32'(flush), 32'h1);
      check("mwait.stall_zero", 32'(stall), 32'h0);
      advance();
      drive_sample(6'b000000, 32'h0);
      check("mwait.rv",  32'(redirect_valid), 32'h1);
      check("mwait.pc",  redirect_pc,         EXC);
      advance();

      // REDIRECT held by a two-cycle fetch stall; exceptions there are ignored.
      run_cycle(6'b000001, 32'h8000_2000);
      for (int i = 0; i < 2; i++) begin
         drive_sample(6'b100010, 32'h0);
         check($sformatf("hold%0d.rv", i),    32'(redirect_valid), 32'h1);
         check($sformatf("hold%0d.stall", i), 32'(stall),          32'h1);
         check($sformatf("hold%0d.flush", i), 32'(flush),          32'h0);
         check($sformatf("hold%0d.pc", i),    redirect_pc,         32'h8000_2000);
         advance();
      end
      drive_sample(6'b000000, 32'h0);
      check("hold.rv_third", 32'(redirect_valid), 32'h1);
      advance();
      drive_sample(6'b000000, 32'h0);
      check("hold.rv_drop", 32'(redirect_valid), 32'h0);
      advance();

      // 300-cycle multi-cycle-unit stall drives the timeout.
      do_reset();
      for (int i = 1; i <= 300; i++) begin
         drive_sample(6'b001000, 32'h0);
         if (i == 256) check("tmo.not_yet", 32'(stall_timeout), 32'h0);
         if (i == 257) check("tmo.set",     32'(stall_timeout), 32'h1);
         advance();
      end
      drive_sample(6'b000000, 32'h0);
      check("tmo.cycles",  stall_cycles,        32'd300);
      check("tmo.sticky",  32'(stall_timeout),  32'h1);
      advance();

      // Asynchronous reset in the middle of REDIRECT.
      run_cycle(6'b000010, 32'h0);
      drive_sample(6'b100000, 32'h0);
      check("areset.pre_rv", 32'(redirect_valid), 32'h1);
      #2;
      drive(6'b111111, 32'hFFFF_FFFF);
      rst = 1'b1;
      #1;
      check_reset_outputs("areset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      drive_sample(6'b011000, 32'h0);
      check("areset.after_stall", 32'(stall),          32'h7);
      check("areset.after_rv",    32'(redirect_valid), 32'h0);
      advance();

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 4000; i++) begin
         logic [5:0] r;
         r[5] = ($urandom_range(0, 3) == 0);
         r[4] = ($urandom_range(0, 5) == 0);
         r[3] = ($urandom_range(0, 5) == 0);
         r[2] = ($urandom_range(0, 4) == 0);
         r[1] = ($urandom_range(0, 9) == 0);
         r[0] = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 499) == 0) do_reset();
         else run_cycle(r, $urandom());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
